sha256_round_controller: RTL
============================

// Module: sha256_round_controller
// PURPOSE
// Iterative SHA-256 compression controller. Accepts one 512-bit message block plus a
// 256-bit chaining state, and drives an external single-round SHA256_Digester for 64
// consecutive cycles: round 0 from the latched inputs, rounds 1..63 by feeding the
// digester's registered outputs back. It supplies each round constant K[r] from an
// internal ROM, adds the result to the input state word-by-word, and presents the hash
// on a valid/ready output.
// PARAMETERS
// NUM_ROUNDS  64  rounds per block; only 64 gives SHA-256; smaller values for debug sims only
// PORTS
// clk          in   1    clock, rising edge
// rst          in   1    synchronous active-high reset
// in_valid     in   1    job request
// in_ready     out  1    high only in IDLE
// in_state     in   256  chaining state; a=[31:0],b=[63:32]..h=[255:224]
// in_block     in   512  message block; W0=[31:0] .. W15=[511:480]
// dg_k         out  32   round constant to digester k
// dg_w         out  512  to digester rx_w
// dg_state     out  256  to digester rx_state
// dg_tx_w      in   512  from digester tx_w
// dg_tx_state  in   256  from digester tx_state
// out_valid    out  1    hash valid, held until accepted
// out_ready    in   1    consumer accepts
// out_hash     out  256  final hash, same word packing as in_state
// busy         out  1    high in RUN or ADD
// round        out  6    current round index, 0 outside RUN
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, out_valid=0, out_hash=0, busy=0, round=0; internal
//   state/block regs=0. The digester has no reset; its outputs are ignored outside RUN/ADD.
// - FSM IDLE->RUN on in_valid&in_ready; latch in_state and in_block at that edge (E0); round<=0.
// - RUN, round r: dg_k=K[r] (combinational ROM, FIPS 180-4 table); if r==0, dg_w=latched
//   block and dg_state=latched state; else dg_w=dg_tx_w and dg_state=dg_tx_state.
//   round increments every edge; on r==NUM_ROUNDS-1 go to ADD.
// - ADD: one cycle; out_hash[32i+31:32i] <= latched_state word i + dg_tx_state word i,
//   each mod 2^32, no carry across words; out_valid<=1; go to DONE.
// - Latency: out_valid rises after edge E(NUM_ROUNDS+1) = E65 counted from accept edge E0.
// - DONE: out_hash/out_valid stable until out_valid&out_ready; then out_valid<=0, go to IDLE.
//   in_ready rises the cycle after; there is no accept in the same cycle as the handoff.
// - in_valid while busy is ignored (in_ready=0); inputs need not be held after E0.
// - dg_k, dg_w and dg_state are don't-care (driven 0) outside RUN.
// - rst mid-RUN/ADD/DONE: job discarded, everything returns to reset values on that edge,
//   no out_valid pulse.
// - round counter never wraps; values >= NUM_ROUNDS are unreachable.
// TESTING
// - "abc": in_state=IV (a=6a09e667..h=5be0cd19), W0=61626380, W15=00000018, others 0 ->
//   out_hash[31:0]=ba7816bf .. [255:224]=f20015ad, out_valid exactly 65 edges after accept.
// - Backpressure: out_ready=0 for 20 cycles -> out_valid and out_hash stable, in_ready=0
//   throughout; one out_ready pulse -> out_valid drops, in_ready=1 next cycle.
// - Back-to-back: two jobs, second in_valid held -> second accepted the cycle after the first
//   handoff; two-block "abcdbcdecdefdefg...nopq" chain, feeding block 1 result as block 2
//   in_state -> 248d6a61..19db06c1.
// - in_valid asserted during RUN with different data -> ignored, "abc" result unchanged.
// - rst at round 30 -> out_valid never asserts, in_ready=1 after reset; next "abc" job correct.
// - K ROM probe: dg_k at round 0 = 428a2f98, round 63 = c67178f2; dg_w/dg_state muxed
//   from inputs only at round 0.

Source files
------------

// File: rtl/sha256_round_controller.sv
// Iterative SHA-256 compression controller: sequences an external single-round digester
// through NUM_ROUNDS rounds, then adds the chaining state and hands off the hash.
module sha256_round_controller #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_state,
   input  logic [511:0] in_block,
   output logic [31:0]  dg_k,
   output logic [511:0] dg_w,
   output logic [255:0] dg_state,
   input  logic [511:0] dg_tx_w,
   input  logic [255:0] dg_tx_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_hash,
   output logic         busy,
   output logic [5:0]   round,
   output logic [1:0]   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid/out_hash hold until that edge, and in_ready is high only while idle.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADD, S_DONE} state_t;

   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t       r_state;
   logic         r_in_ready;
   logic         r_busy;
   logic         r_out_valid;
   logic [5:0]   r_round;
   logic [255:0] r_chain;
   logic [511:0] r_block;
   logic [255:0] r_hash;

   logic         w_run;
   logic [255:0] w_sum;

   assign w_run = (r_state == S_RUN);

   // Round 0 feeds the latched job; later rounds close the loop through the digester.
   always_comb begin
      dg_k     = '0;
      dg_w     = '0;
      dg_state = '0;
      if (w_run) begin
         dg_k = K_ROM[r_round];
         if (r_round == 6'd0) begin
            dg_w     = r_block;
            dg_state = r_chain;
         end else begin
            dg_w     = dg_tx_w;
            dg_state = dg_tx_state;
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 8; i++) begin
         w_sum[32*i +: 32] = r_chain[32*i +: 32] + dg_tx_state[32*i +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_round     <= '0;
         r_chain     <= '0;
         r_block     <= '0;
         r_hash      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_chain    <= in_state;
                  r_block    <= in_block;
                  r_round    <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_round == LAST_ROUND) begin
                  r_round <= '0;
                  r_state <= S_ADD;
               end else begin
                  r_round <= r_round + 6'd1;
               end
            end
            S_ADD: begin
               r_hash      <= w_sum;
               r_out_valid <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               // Handoff edge returns to idle; a new job can only be taken on a later edge.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_hash  = r_hash;
   assign round     = r_round;
   assign dbg_state = r_state;

endmodule
